// File: rtl/sdr_pkg.sv
// Shared definitions for the SDR transmit path: framer FSM states,
// BPSK mapper symbol codes and the default frame sync word.
package sdr_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_PREAMBLE,
      ST_SYNC,
      ST_PAYLOAD
   } state_t;

   localparam logic [3:0]  BIT0_CODE         = 4'b0000;
   localparam logic [3:0]  BIT1_CODE         = 4'b0001;
   localparam logic [15:0] DEFAULT_SYNC_WORD = 16'hF0A5;

endpackage

// File: rtl/byte_serializer.sv
// Payload byte path: one-byte holding register feeding an 8-bit MSB-first
// shift register, with the bit count tracked alongside the data.
module byte_serializer (
   input  logic       clk,
   input  logic       rst,
   input  logic       clear,
   input  logic       accept_en,
   input  logic [7:0] data_in,
   input  logic       data_valid,
   input  logic       shift,
   output logic       data_ready,
   output logic       bit_avail,
   output logic       cur_bit,
   output logic       last_bit
);

   logic [7:0] shift_reg;
   logic [7:0] hold_reg;
   logic [3:0] shift_cnt;
   logic       hold_full;

   logic       use_hold;
   logic [7:0] eff_reg;
   logic [3:0] eff_cnt;
   logic       do_shift;
   logic       reload;
   logic       transfer;

   // An empty shift register sees through to a full holding register, so a
   // symbol strobe never waits a cycle for the load.
   assign use_hold   = (shift_cnt == 4'd0) && hold_full;
   assign eff_reg    = use_hold ? hold_reg : shift_reg;
   assign eff_cnt    = use_hold ? 4'd8 : shift_cnt;

   assign bit_avail  = (eff_cnt != 4'd0);
   assign cur_bit    = eff_reg[7];
   assign last_bit   = (eff_cnt == 4'd1);

   assign do_shift   = shift && bit_avail;
   assign reload     = use_hold || (do_shift && last_bit && hold_full);
   assign data_ready = accept_en && !hold_full;
   assign transfer   = data_ready && data_valid;

   // NOTE: the holding register is reset like any control state so a frame
   // aborted by reset can never leak a stale byte into the next one.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shift_reg <= 8'h00;
         hold_reg  <= 8'h00;
         shift_cnt <= 4'd0;
         hold_full <= 1'b0;
      end else if (clear) begin
         shift_reg <= 8'h00;
         hold_reg  <= 8'h00;
         shift_cnt <= 4'd0;
         hold_full <= 1'b0;
      end else begin
         if (do_shift && last_bit && hold_full) begin
            shift_reg <= hold_reg;
            shift_cnt <= 4'd8;
         end else if (do_shift) begin
            shift_reg <= {eff_reg[6:0], 1'b0};
            shift_cnt <= eff_cnt - 4'd1;
         end else if (use_hold) begin
            shift_reg <= hold_reg;
            shift_cnt <= 4'd8;
         end
         if (transfer) begin
            hold_reg <= data_in;
         end
         hold_full <= (hold_full && !reload) || transfer;
      end
   end

endmodule

// File: rtl/bpsk_framer.sv
// BPSK frame generator: alternating preamble, MSB-first sync word, then
// payload_len bytes, one registered bit per symbol strobe.
module bpsk_framer
   import sdr_pkg::*;
#(
   parameter int          PREAMBLE_LEN = 16,
   parameter logic [15:0] SYNC_WORD    = DEFAULT_SYNC_WORD
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sym_en,
   input  logic       start,
   input  logic [7:0] payload_len,
   input  logic [7:0] data_in,
   input  logic       data_valid,
   output logic       data_ready,
   output logic [3:0] bit_out,
   output logic       bit_valid,
   output logic       busy,
   output logic       done,
   output logic       underrun
);

   localparam logic [6:0] PRE_LAST = 7'(PREAMBLE_LEN - 1);

   state_t     state, state_d;
   logic [6:0] bit_cnt;
   logic [7:0] len_q;
   logic [7:0] bytes_acc;
   logic [7:0] bytes_done;
   logic [3:0] sync_idx;

   logic emit, emit_one, frame_done, underrun_set;
   logic ser_shift, accept_start, cnt_clr, cnt_inc;
   logic ser_avail, ser_bit, ser_last, transfer;

   assign busy     = (state != ST_IDLE);
   assign sync_idx = 4'd15 - bit_cnt[3:0];
   assign transfer = data_valid && data_ready;

   byte_serializer u_ser (
      .clk        (clk),
      .rst        (rst),
      .clear      (accept_start),
      .accept_en  (busy && (bytes_acc < len_q)),
      .data_in    (data_in),
      .data_valid (data_valid),
      .shift      (ser_shift),
      .data_ready (data_ready),
      .bit_avail  (ser_avail),
      .cur_bit    (ser_bit),
      .last_bit   (ser_last)
   );

   // NOTE: every combinational output gets a default before the case, so no
   // path through the decode can infer a latch.
   always_comb begin
      state_d      = state;
      emit         = 1'b0;
      emit_one     = 1'b0;
      frame_done   = 1'b0;
      underrun_set = 1'b0;
      ser_shift    = 1'b0;
      accept_start = 1'b0;
      cnt_clr      = 1'b0;
      cnt_inc      = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (start) begin
               state_d      = ST_PREAMBLE;
               accept_start = 1'b1;
            end
         end
         ST_PREAMBLE: begin
            if (sym_en) begin
               emit     = 1'b1;
               emit_one = ~bit_cnt[0];
               if (bit_cnt == PRE_LAST) begin
                  state_d = ST_SYNC;
                  cnt_clr = 1'b1;
               end else begin
                  cnt_inc = 1'b1;
               end
            end
         end
         ST_SYNC: begin
            if (sym_en) begin
               emit     = 1'b1;
               emit_one = SYNC_WORD[sync_idx];
               if (bit_cnt == 7'd15) begin
                  cnt_clr = 1'b1;
                  if (len_q == 8'd0) begin
                     state_d    = ST_IDLE;
                     frame_done = 1'b1;
                  end else begin
                     state_d = ST_PAYLOAD;
                  end
               end else begin
                  cnt_inc = 1'b1;
               end
            end
         end
         ST_PAYLOAD: begin
            if (sym_en) begin
               if (ser_avail) begin
                  emit      = 1'b1;
                  emit_one  = ser_bit;
                  ser_shift = 1'b1;
                  if (ser_last && (bytes_done == len_q - 8'd1)) begin
                     state_d    = ST_IDLE;
                     frame_done = 1'b1;
                  end
               end else begin
                  // Nothing to send: abort without a done pulse.
                  underrun_set = 1'b1;
                  state_d      = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: all state below uses non-blocking assignments so every register
   // samples pre-edge values regardless of process ordering.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_IDLE;
         bit_cnt    <= 7'd0;
         len_q      <= 8'd0;
         bytes_acc  <= 8'd0;
         bytes_done <= 8'd0;
         bit_out    <= BIT0_CODE;
         bit_valid  <= 1'b0;
         done       <= 1'b0;
         underrun   <= 1'b0;
      end else begin
         state     <= state_d;
         bit_valid <= emit;
         bit_out   <= (emit && emit_one) ? BIT1_CODE : BIT0_CODE;
         done      <= frame_done;
         if (accept_start) begin
            len_q      <= payload_len;
            bytes_acc  <= 8'd0;
            bytes_done <= 8'd0;
            bit_cnt    <= 7'd0;
            underrun   <= 1'b0;
         end else begin
            if (underrun_set) underrun <= 1'b1;
            if (cnt_clr) begin
               bit_cnt <= 7'd0;
            end else if (cnt_inc) begin
               bit_cnt <= bit_cnt + 7'd1;
            end
            if (transfer) bytes_acc <= bytes_acc + 8'd1;
            if (ser_shift && ser_last) bytes_done <= bytes_done + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_bpsk_framer.sv
// Directed bench for bpsk_framer: frame contents, underrun, reset abort,
// ignored restart and back-to-back frames against hand-computed patterns.
module tb_bpsk_framer;

   logic       clk = 1'b0;
   logic       rst;
   logic       sym_en = 1'b0;
   logic       start = 1'b0;
   logic [7:0] payload_len = 8'd0;
   logic [7:0] data_in;
   logic       data_valid;
   logic       data_ready;
   logic [3:0] bit_out;
   logic       bit_valid;
   logic       busy;
   logic       done;
   logic       underrun;

   int n_tests = 0;
   int n_fail  = 0;

   // stimulus helpers
   logic [7:0] pay_mem [0:3];
   logic [7:0] byte_idx = 8'd0;
   int         feed_limit = 0;
   logic       feed_clr = 1'b0;
   int         sym_phase = 0;

   // monitor state
   logic       mon_clr = 1'b0;
   logic       bits [0:127];
   int         n_bits = 0;
   int         n_done = 0;
   int         done_idx = 0;
   int         bad_out = 0;
   logic       saw_ready = 1'b0;

   bpsk_framer #(.PREAMBLE_LEN(16), .SYNC_WORD(16'hF0A5)) dut (
      .clk         (clk),
      .rst         (rst),
      .sym_en      (sym_en),
      .start       (start),
      .payload_len (payload_len),
      .data_in     (data_in),
      .data_valid  (data_valid),
      .data_ready  (data_ready),
      .bit_out     (bit_out),
      .bit_valid   (bit_valid),
      .busy        (busy),
      .done        (done),
      .underrun    (underrun)
   );

   always #5 clk = ~clk;

   // symbol strobe: one cycle in four
   always @(negedge clk) begin
      sym_phase = (sym_phase + 1) % 4;
      sym_en    = (sym_phase == 0);
   end

   assign data_in    = pay_mem[byte_idx[1:0]];
   assign data_valid = (int'(byte_idx) < feed_limit);

   always @(posedge clk) begin
      if (feed_clr) byte_idx <= 8'd0;
      else if (data_valid && data_ready) byte_idx <= byte_idx + 8'd1;
   end

   always @(negedge clk) begin
      if (mon_clr) begin
         n_bits    = 0;
         n_done    = 0;
         done_idx  = 0;
         bad_out   = 0;
         saw_ready = 1'b0;
      end else begin
         if (bit_valid) begin
            if (n_bits < 128) bits[n_bits] = bit_out[0];
            if (bit_out[3:1] != 3'b000) bad_out++;
            n_bits++;
         end else if (bit_out != 4'b0000) begin
            bad_out++;
         end
         if (done) begin
            n_done++;
            done_idx = n_bits;
         end
         if (data_ready) saw_ready = 1'b1;
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] pack(input int from, input int n);
      logic [63:0] v = 64'd0;
      for (int i = 0; i < n; i++) v = {v[62:0], bits[from + i]};
      return v;
   endfunction

   // start aligned with a symbol strobe, which must not produce a bit
   task automatic run_frame(input int len, input int limit);
      payload_len = 8'(len);
      feed_limit  = limit;
      feed_clr    = 1'b1;
      mon_clr     = 1'b1;
      @(negedge clk);
      feed_clr = 1'b0;
      mon_clr  = 1'b0;
      @(posedge sym_en);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      logic timed_out = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (!busy) begin
            timed_out = 1'b0;
            break;
         end
      end
      repeat (3) @(negedge clk);
      check({tag, "_timeout"}, 64'(timed_out), 64'd0);
   endtask

   task automatic check_frame(input string tag, input int len, input logic [63:0] pay);
      check({tag, "_nbits"}, 64'(n_bits), 64'(32 + 8 * len));
      check({tag, "_pre"}, pack(0, 16), 64'hAAAA);
      check({tag, "_sync"}, pack(16, 16), 64'hF0A5);
      if (len > 0) check({tag, "_pay"}, pack(32, 8 * len), pay);
      check({tag, "_ndone"}, 64'(n_done), 64'd1);
      check({tag, "_doneidx"}, 64'(done_idx), 64'(32 + 8 * len));
      check({tag, "_codes"}, 64'(bad_out), 64'd0);
      check({tag, "_flags"}, {62'd0, busy, underrun}, 64'd0);
   endtask

   initial begin
      int n_at_rst;
      logic tmo;

      rst = 1'b1;
      start = 1'b1;
      repeat (3) @(negedge clk);
      check("reset_outputs", {58'd0, bit_out, bit_valid, busy, done, underrun, data_ready}, 64'd0);
      start = 1'b0;
      rst = 1'b0;

      // symbol strobes in IDLE produce nothing
      mon_clr = 1'b1;
      @(negedge clk);
      mon_clr = 1'b0;
      repeat (20) @(negedge clk);
      check("idle_nbits", 64'(n_bits), 64'd0);
      check("idle_busy", 64'(busy), 64'd0);

      // single byte C3
      pay_mem[0] = 8'hC3;
      run_frame(1, 255);
      check("s1_busy_after_start", 64'(busy), 64'd1);
      wait_idle("s1");
      check_frame("s1", 1, 64'hC3);

      // empty payload: preamble + sync, data_ready never asserted
      run_frame(0, 255);
      wait_idle("s2");
      check_frame("s2", 0, 64'd0);
      check("s2_ready_seen", 64'(saw_ready), 64'd0);

      // underrun after the first of three bytes
      pay_mem[0] = 8'h5A;
      run_frame(3, 1);
      wait_idle("s3");
      check("s3_nbits", 64'(n_bits), 64'd40);
      check("s3_pay", pack(32, 8), 64'h5A);
      check("s3_flags", {61'd0, busy, underrun, 1'b0}, 64'b010);
      check("s3_ndone", 64'(n_done), 64'd0);
      repeat (10) @(negedge clk);
      check("s3_sticky", 64'(underrun), 64'd1);

      // reset at the 5th sync bit, then a clean frame
      pay_mem[0] = 8'hC3;
      run_frame(1, 255);
      check("s4_underrun_cleared", 64'(underrun), 64'd0);
      tmo = 1'b1;
      for (int i = 0; i < 2000; i++) begin
         @(posedge clk);
         #1;
         if (bit_valid && n_bits == 20) begin
            tmo = 1'b0;
            break;
         end
      end
      check("s4_reach_sync5", 64'(tmo), 64'd0);
      rst = 1'b1;
      #1;
      check("s4_rst_outputs", {58'd0, bit_out, bit_valid, busy, done, underrun, data_ready}, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      n_at_rst = n_bits;
      repeat (40) @(negedge clk);
      check("s4_no_resume_bits", 64'(n_bits), 64'(n_at_rst));
      check("s4_no_resume_busy", 64'(busy), 64'd0);
      run_frame(1, 255);
      wait_idle("s4b");
      check_frame("s4b", 1, 64'hC3);

      // start pulsed mid-payload is ignored
      pay_mem[0] = 8'h3C;
      pay_mem[1] = 8'h96;
      run_frame(2, 255);
      tmo = 1'b1;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (n_bits >= 36) begin
            tmo = 1'b0;
            break;
         end
      end
      check("s5_reach_payload", 64'(tmo), 64'd0);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_idle("s5");
      check_frame("s5", 2, 64'h3C96);

      // back-to-back 00/FF frames
      pay_mem[0] = 8'h00;
      pay_mem[1] = 8'hFF;
      for (int f = 0; f < 2; f++) begin
         run_frame(2, 255);
         wait_idle("s6");
         check_frame("s6", 2, 64'h00FF);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/bpsk_framer.md
BPSK_FRAMER -- requirements
Module: bpsk_framer

Interface
REQ-001 Parameter PREAMBLE_LEN, default 16, number of preamble bits, range 2..64.
REQ-002 Parameter SYNC_WORD, default 16'hF0A5, sync pattern, sent MSB-first.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 sym_en  input  1  single-cycle symbol-rate strobe.
REQ-007 start  input  1  request a frame; sampled only in IDLE.
REQ-008 payload_len  input  8  payload byte count, latched on accepted start.
REQ-009 data_in  input  8  payload byte, sent MSB-first.
REQ-010 data_valid  input  1  data_in valid.
REQ-011 data_ready  output  1  block accepts data_in this cycle.
REQ-012 bit_out  output  4  symbol code to the BPSK mapper: 4'b0000 for bit 0, 4'b0001 for bit 1.
REQ-013 bit_valid  output  1  bit_out carries a frame bit; high for exactly one cycle per emitted bit.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 done  output  1  one-cycle pulse after the last frame bit.
REQ-016 underrun  output  1  sticky error flag; cleared only by reset or by the next accepted start.

Function
REQ-017 The FSM SHALL have the states IDLE, PREAMBLE, SYNC and PAYLOAD.
REQ-018 IDLE->PREAMBLE SHALL occur on start=1; the block latches payload_len, clears underrun and clears the bit/byte counters.
REQ-019 Each state SHALL emit one bit per sym_en; bit_out/bit_valid are registered and update the cycle after sym_en (latency 1).
REQ-020 PREAMBLE SHALL emit alternating bits starting with 1 (1,0,1,0,...) for PREAMBLE_LEN sym_en, then go to SYNC.
REQ-021 SYNC SHALL emit the 16 SYNC_WORD bits MSB-first, then go to PAYLOAD, or to IDLE with done if payload_len=0.
REQ-022 PAYLOAD SHALL use an 8-bit shift register plus a one-byte holding register; the shift register reloads from the holding register after bit 0.
REQ-023 data_ready = busy AND holding register empty AND bytes_accepted < latched payload_len; a transfer occurs when data_valid AND data_ready.
REQ-024 After the last bit of byte number payload_len is emitted, the block SHALL go to IDLE and pulse done on the same cycle as that bit's bit_valid.
REQ-025 Underrun: if, at a PAYLOAD sym_en, the shift register is empty and the holding register is empty, the block SHALL emit no bit, set underrun, go to IDLE, and not pulse done.
REQ-026 When bit_valid=0, bit_out SHALL read 4'b0000.
REQ-027 start while busy SHALL be ignored and SHALL NOT restart the frame.
REQ-028 start and sym_en in the same IDLE cycle: the first preamble bit SHALL follow the next sym_en, not that one.
REQ-029 sym_en in IDLE SHALL produce no output.
REQ-030 A transfer and a shift-register reload in the same cycle SHALL both take effect without losing a byte.

Reset
REQ-031 rst SHALL force IDLE immediately, including mid-frame.
REQ-032 During and after reset, bit_out=0, bit_valid=0, busy=0, done=0, underrun=0 and data_ready=0.
REQ-033 Reset SHALL clear the holding and shift registers and all counters; no partial frame resumes after reset.

Structure
REQ-034 A shared package (sdr_pkg) SHALL hold the state enum, the constants BIT0_CODE=4'b0000 and BIT1_CODE=4'b0001, and the default SYNC_WORD.
REQ-035 The byte holding/shift logic SHALL be one sub-module, byte_serializer; the FSM and counters stay in bpsk_framer.

Verification
REQ-036 Scenario: PREAMBLE_LEN=16, payload_len=1, data 8'hC3, sym_en every 4 cycles, data_valid always high -> 40 bit_valid pulses: 1010...(16), F0A5, then 11000011; done with the 40th bit.
REQ-037 Scenario: payload_len=0 -> 32 bits (preamble + sync), then done; data_ready never high.
REQ-038 Scenario: payload_len=3, data_valid withheld after byte 1 -> 8 payload bits emitted, then underrun=1, busy=0, no done.
REQ-039 Scenario: rst asserted at the 5th sync bit -> all outputs 0 the same cycle; a new start later yields a full, correct frame.
REQ-040 Scenario: start pulsed mid-PAYLOAD -> frame bit sequence unchanged, exactly one done.
REQ-041 Scenario: back-to-back frames of 2 bytes (8'h00, 8'hFF) -> bit_out is 0000 for 8 bits, then 0001 for 8 bits; bit_valid count = 48 per frame.
